module_medidor_periodo: RTL and testbench
=========================================

# module_medidor_periodo

Period meter that receives a slow square wave, such as a divided-clock output, and measures the spacing between its edges in system-clock cycles. `sig_in` is asynchronous to `clk`. The block synchronizes it, detects both edges, and reports each half-period with a one-cycle valid strobe. A timeout flag marks a stalled or absent input. It is the receiving end of the clock-divider output: a divider toggling every N cycles reads back as `half_prd = N`.

## Interface
- `WIDTH`, 16: width of the cycle counter and of `half_prd`; saturation value is 2^WIDTH−1.
- `SYNC_STAGES`, 2: number of synchronizer flops on `sig_in`; minimum 2.
- `clk` in 1: system clock; every register uses its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sig_in` in 1: measured signal, asynchronous.
- `enable` in 1: measurement enable, level.
- `half_prd` out WIDTH: last measured edge-to-edge spacing in clk cycles.
- `prd_valid` out 1: one-cycle strobe when `half_prd` is updated.
- `timeout` out 1: high when no edge has arrived for 2^WIDTH−1 cycles.
- `level` out 1: synchronized `sig_in`, equal to the last synchronizer stage.

## Operation
- Synchronizer: a `SYNC_STAGES`-deep flop chain feeds `level`. A further flop holds `prev`. `edge = level ^ prev`; both rising and falling edges count.
- FSM states are IDLE, ARM and MEASURE. All outputs are registered.
- IDLE:
  - Counter is 0.
  - Go to ARM when `enable` = 1.
- ARM (waiting for the first edge; no measurement yet):
  - On `edge`: counter ← 1, go to MEASURE. No `prd_valid`, since the first edge only starts the count.
- MEASURE:
  - Without `edge`: counter ← counter+1.
  - On `edge`: `half_prd` ← counter, `prd_valid` ← 1, `timeout` ← 0, counter ← 1, stay in MEASURE.
- Timeout:
  - Applies in MEASURE when counter = 2^WIDTH−1 and there is no `edge`.
  - `timeout` ← 1, counter ← 0, go to ARM.
  - `half_prd` holds its value and no `prd_valid` is issued.
  - `timeout` stays high until the next valid measurement, `rst`, or `enable` going low.
- An `edge` on the same cycle the counter reaches 2^WIDTH−1 is a valid measurement: `half_prd` = 2^WIDTH−1, no timeout.
- `enable` low in any state:
  - Next state is IDLE, counter ← 0, `timeout` ← 0.
  - `half_prd` holds its value and `prd_valid` is 0.
  - A measurement in progress is discarded, and the next `enable` re-arms the block without reporting.
- `enable` low and `edge` on the same cycle: `enable` wins and no strobe is issued.
- Measurement is exact for any spacing ≥ 1 cycle. A `sig_in` toggling every clk gives `half_prd` = 1 on every cycle.

## Timing
- Reset values (the synchronous `rst` takes priority over everything):
  - State IDLE, counter 0.
  - `half_prd` 0, `prd_valid` 0, `timeout` 0.
  - Synchronizer flops, `prev` and `level` all 0.
- `rst` in the middle of a measurement discards it. After `rst` falls, at least one full edge pair is needed before the first `prd_valid`.
- Latency: a `sig_in` transition first sampled at clk edge k gives `prd_valid` high in the cycle after edge k+`SYNC_STAGES`. With the default that is 3 clocks.
- `prd_valid` is exactly one cycle wide. `half_prd` changes only on a `prd_valid` cycle, or on `rst`.
- Edges spaced N cycles apart at `sig_in` appear N cycles apart at `edge`, so `half_prd` = N with no off-by-one.
- Timeout asserts 2^WIDTH−1 cycles after the last counted edge.

## Test plan
- Square wave toggling every 5 clk, `enable` = 1 after `rst` → the first edge is not reported; each later edge gives `half_prd` = 5 with a one-cycle `prd_valid`, spaced 5 cycles apart.
- Toggle every 1 clk → `prd_valid` is high every cycle with `half_prd` = 1. Then switch to toggling every 13500 clk → after one transitional value, the reports settle at `half_prd` = 13500.
- `WIDTH` = 8, one edge then `sig_in` held constant → `timeout` = 1 exactly 255 cycles after the counted edge, with no `prd_valid`. Next edges 10 apart → the first only re-arms; the second gives `half_prd` = 10 and clears `timeout`.
- `WIDTH` = 8, edges exactly 255 apart → `half_prd` = 255, `timeout` stays 0.
- `enable` dropped for 1 cycle in the middle of a half-period → no strobe for that interval; `half_prd` keeps its old value; reporting resumes from the second edge after re-enable.
- `rst` asserted while in MEASURE with `half_prd` = 7 → the next cycle shows `half_prd` = 0, `prd_valid` = 0, `timeout` = 0, and the state is IDLE.

Source files
------------

// File: rtl/module_medidor_periodo.sv
// module_medidor_periodo: measures the edge-to-edge spacing of an asynchronous square wave
// in clk cycles, with a one-cycle valid strobe and a stall timeout.
module module_medidor_periodo #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic [WIDTH-1:0] half_prd,
   output logic             prd_valid,
   output logic             timeout,
   output logic             level
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;
   localparam logic [WIDTH-1:0] CMAX = '1;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_w;
   logic [WIDTH-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       half_prd_q, half_prd_d;
   logic                   prd_valid_q, prd_valid_d;
   logic                   timeout_q, timeout_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign level  = sync_q[SYNC_STAGES-1];
   assign edge_w = level ^ prev_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         half_prd_q  <= '0;
         prd_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         half_prd_q  <= half_prd_d;
         prd_valid_q <= prd_valid_d;
         timeout_q   <= timeout_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (!enable) state_d = IDLE;
      else if (state_q == IDLE) state_d = ARM;
      else if (state_q == ARM) state_d = edge_w ? MEASURE : ARM;
      else state_d = (!edge_w && cnt_q == CMAX) ? ARM : MEASURE;
   end
   // an edge coinciding with a saturated counter still counts as a measurement
   always_comb begin
      cnt_d       = cnt_q;
      half_prd_d  = half_prd_q;
      prd_valid_d = 1'b0;
      timeout_d   = timeout_q;
      if (!enable) begin
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == ARM) begin
         cnt_d = edge_w ? ONE : cnt_q;
      end else if (edge_w) begin
         half_prd_d  = cnt_q;
         prd_valid_d = 1'b1;
         timeout_d   = 1'b0;
         cnt_d       = ONE;
      end else if (cnt_q == CMAX) begin
         timeout_d = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end
   assign half_prd  = half_prd_q;
   assign prd_valid = prd_valid_q;
   assign timeout   = timeout_q;
endmodule

// File: tb/tb_module_medidor_periodo.sv
// tb_module_medidor_periodo: directed checks of the period meter at WIDTH 16 and WIDTH 8.
module tb_module_medidor_periodo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig_a = 1'b0, en_a = 1'b0, sig_b = 1'b0, en_b = 1'b0;
   logic [15:0] a_half;
   logic [7:0]  b_half;
   logic        a_pv, a_to, a_lvl, b_pv, b_to, b_lvl;
   int          vecs = 0;
   int          errs = 0;
   logic        seen;

   always #5 clk = ~clk;

   module_medidor_periodo dut_a (
      .clk(clk), .rst(rst), .sig_in(sig_a), .enable(en_a),
      .half_prd(a_half), .prd_valid(a_pv), .timeout(a_to), .level(a_lvl)
   );
   module_medidor_periodo #(.WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .sig_in(sig_b), .enable(en_b),
      .half_prd(b_half), .prd_valid(b_pv), .timeout(b_to), .level(b_lvl)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      step; step; step;
      chk("rst_a_half", 32'(a_half), 0);
      chk("rst_a_pv", 32'(a_pv), 0);
      chk("rst_a_to", 32'(a_to), 0);
      chk("rst_a_lvl", 32'(a_lvl), 0);
      chk("rst_b_half", 32'(b_half), 0);
      chk("rst_b_to", 32'(b_to), 0);
      rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
      for (int e = 0; e < 4; e++) begin
         sig_a = ~sig_a;
         for (int i = 0; i < 5; i++) begin
            step;
            chk("sq5_pv", 32'(a_pv), (i == 2 && e > 0) ? 1 : 0);
            if (i == 2 && e > 0) chk("sq5_half", 32'(a_half), 5);
         end
      end
      chk("sq5_to", 32'(a_to), 0);
      for (int i = 0; i < 12; i++) begin
         sig_a = ~sig_a;
         step;
         if (i >= 3) begin
            chk("fast_pv", 32'(a_pv), 1);
            chk("fast_half", 32'(a_half), 1);
         end
      end
      for (int e = 0; e < 3; e++) begin
         sig_a = ~sig_a;
         for (int i = 0; i < 13500; i++) begin
            step;
            if (i == 2 && e > 0) begin
               chk("slow_pv", 32'(a_pv), 1);
               chk("slow_half", 32'(a_half), 13500);
            end
         end
      end
      chk("slow_to", 32'(a_to), 0);
      sig_b = 1'b1;
      seen = 1'b0;
      for (int i = 1; i <= 257; i++) begin
         step;
         seen = seen | b_pv;
      end
      chk("to_nopv", 32'(seen), 0);
      chk("to_early", 32'(b_to), 0);
      step;
      chk("to_set", 32'(b_to), 1);
      chk("to_pv", 32'(b_pv), 0);
      chk("to_half", 32'(b_half), 0);
      sig_b = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step;
         if (i == 3) begin
            chk("rearm_pv", 32'(b_pv), 0);
            chk("rearm_to", 32'(b_to), 1);
         end
      end
      sig_b = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         step;
         if (i == 3) begin
            chk("after_to_pv", 32'(b_pv), 1);
            chk("after_to_half", 32'(b_half), 10);
            chk("after_to_clr", 32'(b_to), 0);
         end
      end
      sig_b = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step;
         if (i == 3) begin
            chk("max_pv", 32'(b_pv), 1);
            chk("max_half", 32'(b_half), 255);
            chk("max_to", 32'(b_to), 0);
         end
         if (i == 4) chk("max_pv_width", 32'(b_pv), 0);
      end
      en_b = 1'b0;
      step;
      en_b = 1'b1;
      step;
      chk("dis_pv", 32'(b_pv), 0);
      chk("dis_half", 32'(b_half), 255);
      sig_b = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step;
         if (i == 3) begin
            chk("reen_first_pv", 32'(b_pv), 0);
            chk("reen_first_half", 32'(b_half), 255);
         end
      end
      sig_b = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step;
         if (i == 3) begin
            chk("reen_pv", 32'(b_pv), 1);
            chk("reen_half", 32'(b_half), 6);
         end
      end
      sig_a = ~sig_a;
      for (int i = 0; i < 7; i++) step;
      sig_a = ~sig_a;
      step; step; step;
      chk("pre_rst_pv", 32'(a_pv), 1);
      chk("pre_rst_half", 32'(a_half), 7);
      rst = 1'b1; sig_a = 1'b0;
      step;
      chk("mrst_half", 32'(a_half), 0);
      chk("mrst_pv", 32'(a_pv), 0);
      chk("mrst_to", 32'(a_to), 0);
      chk("mrst_lvl", 32'(a_lvl), 0);
      chk("mrst_state", 32'(dut_a.state_q), 0);
      step;
      rst = 1'b0;
      sig_a = 1'b1;
      step; step; step;
      chk("post_rst_first_pv", 32'(a_pv), 0);
      step;
      sig_a = 1'b0;
      step; step; step;
      chk("post_rst_pv", 32'(a_pv), 1);
      chk("post_rst_half", 32'(a_half), 4);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
